// File: rtl/serial_link_pkg.sv
// Shared types and defaults for the serial link virtual-channel credit layer.
package serial_link_pkg;

  localparam int unsigned DefaultNumVc       = 2;
  localparam int unsigned DefaultNumCredits  = 8;
  localparam int unsigned DefaultVcIdWidth   = (DefaultNumVc > 1) ? $clog2(DefaultNumVc) : 1;
  localparam int unsigned DefaultCreditWidth = $clog2(DefaultNumCredits + 1);

  // Link-level packet header for the default channel configuration.
  typedef struct packed {
    logic [DefaultVcIdWidth-1:0]   vc;
    logic                          cred_only;
    logic [DefaultVcIdWidth-1:0]   cred_vc;
    logic [DefaultCreditWidth-1:0] cred;
  } vc_credit_hdr_t;

endpackage

// File: rtl/stream_fifo.sv
// Ready/valid FIFO with synchronous flush; storage is a plain register array.
module stream_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  localparam int unsigned AddrWidth  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CountWidth = AddrWidth + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  typedef logic [AddrWidth-1:0] ptr_t;
  localparam ptr_t                  LastPtr   = ptr_t'(DEPTH - 1);
  localparam logic [CountWidth-1:0] FullCount = CountWidth'(DEPTH);

  ptr_t                  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  push, pop;

  always_comb begin
    ready_o  = (count_q != FullCount);
    valid_o  = (count_q != '0);
    push     = valid_i & ready_o;
    pop      = valid_o & ready_i;
    data_o   = mem_q[rd_ptr_q];
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; valid_o masks stale entries, so clearing the pointers suffices.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/serial_link_vc_credit_ctrl.sv
// Credit-based virtual-channel flow controller: round-robin TX muxing with
// piggybacked credit returns, and per-VC RX buffering sized to the credit pool.
module serial_link_vc_credit_ctrl
  import serial_link_pkg::*;
#(
  parameter int unsigned NumVc           = DefaultNumVc,
  parameter int unsigned DataWidth       = 64,
  parameter int unsigned NumCredits      = DefaultNumCredits,
  parameter int          ForceSendThresh = int'(NumCredits) - 4,
  localparam int unsigned VcIdWidth      = (NumVc > 1) ? $clog2(NumVc) : 1,
  localparam int unsigned CreditWidth    = $clog2(NumCredits + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NumVc-1:0]           tx_valid_i,
  output logic [NumVc-1:0]           tx_ready_o,
  input  logic [NumVc*DataWidth-1:0] tx_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [DataWidth-1:0]       out_data_o,
  output logic [VcIdWidth-1:0]       out_vc_o,
  output logic                       out_cred_only_o,
  output logic [VcIdWidth-1:0]       out_cred_vc_o,
  output logic [CreditWidth-1:0]     out_cred_o,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [DataWidth-1:0]       in_data_i,
  input  logic [VcIdWidth-1:0]       in_vc_i,
  input  logic                       in_cred_only_i,
  input  logic [VcIdWidth-1:0]       in_cred_vc_i,
  input  logic [CreditWidth-1:0]     in_cred_i,
  output logic [NumVc-1:0]           rx_valid_o,
  input  logic [NumVc-1:0]           rx_ready_i,
  output logic [NumVc*DataWidth-1:0] rx_data_o,
  output logic                       overflow_o
);

  typedef logic [CreditWidth-1:0] cred_t;
  typedef logic [VcIdWidth-1:0]   vc_t;

  typedef struct packed {
    vc_t   vc;
    logic  cred_only;
    vc_t   cred_vc;
    cred_t cred;
  } hdr_t;

  localparam cred_t MaxCred    = cred_t'(NumCredits);
  localparam cred_t ThreshCred = cred_t'(ForceSendThresh);
  localparam vc_t   LastVc     = vc_t'(NumVc - 1);

  function automatic vc_t next_vc(input vc_t vc);
    return (vc == LastVc) ? '0 : vc + 1'b1;
  endfunction

  // First requester at or after start, wrapping; start itself when none request.
  function automatic vc_t rr_pick(input logic [NumVc-1:0] req, input vc_t start);
    vc_t  pick;
    vc_t  idx;
    logic found;
    pick  = start;
    idx   = start;
    found = 1'b0;
    for (int i = 0; i < int'(NumVc); i++) begin
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
      idx = next_vc(idx);
    end
    return pick;
  endfunction

  cred_t                avail_q [NumVc];
  cred_t                avail_d [NumVc];
  cred_t                pend_q  [NumVc];
  cred_t                pend_d  [NumVc];
  vc_t                  rr_tx_q, rr_tx_d, rr_cred_q, rr_cred_d;
  logic                 out_valid_q, out_valid_d;
  logic [DataWidth-1:0] out_data_q, out_data_d;
  hdr_t                 hdr_q, hdr_d;
  logic                 overflow_q, overflow_d;

  logic [NumVc-1:0] elig, force_req, pend_nz, fifo_push, fifo_ready;
  logic             any_elig, any_force, cred_any, load_en, load;
  vc_t              grant, force_vc, cred_vc;
  cred_t            cred_amt;

  // NOTE: every always_comb output gets a default before any condition, so no latch can be inferred.
  always_comb begin
    for (int v = 0; v < int'(NumVc); v++) begin
      elig[v]      = tx_valid_i[v] && (avail_q[v] != '0);
      force_req[v] = (pend_q[v] >= ThreshCred);
      pend_nz[v]   = (pend_q[v] != '0);
    end
    any_elig  = |elig;
    any_force = |force_req;
    cred_any  = |pend_nz;
    grant     = rr_pick(elig, rr_tx_q);
    force_vc  = '0;
    for (int v = int'(NumVc) - 1; v >= 0; v--) begin
      if (force_req[v]) force_vc = vc_t'(v);
    end
    cred_vc    = any_force ? force_vc : rr_pick(pend_nz, rr_cred_q);
    cred_amt   = cred_any ? pend_q[cred_vc] : '0;
    load_en    = !out_valid_q || out_ready_i;
    load       = !rst_i && load_en && (any_elig || any_force);
    tx_ready_o = '0;
    if (load && any_elig) tx_ready_o[grant] = 1'b1;
  end

  always_comb begin
    avail_d     = avail_q;
    pend_d      = pend_q;
    rr_tx_d     = rr_tx_q;
    rr_cred_d   = rr_cred_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    hdr_d       = hdr_q;
    overflow_d  = overflow_q;
    fifo_push   = '0;

    if (load) begin
      out_valid_d     = 1'b1;
      out_data_d      = '0;
      hdr_d.vc        = any_elig ? grant : '0;
      hdr_d.cred_only = !any_elig;
      hdr_d.cred_vc   = cred_any ? cred_vc : '0;
      hdr_d.cred      = cred_amt;
      for (int v = 0; v < int'(NumVc); v++) begin
        if (any_elig && grant == vc_t'(v)) out_data_d = tx_data_i[v*DataWidth +: DataWidth];
      end
      if (any_elig) rr_tx_d = next_vc(grant);
      if (cred_any) rr_cred_d = next_vc(cred_vc);
    end else if (load_en) begin
      out_valid_d = 1'b0;
    end

    // Same-VC events compose: send and inbound credit on avail, return and drain on pend.
    for (int v = 0; v < int'(NumVc); v++) begin
      if (load && any_elig && grant == vc_t'(v)) avail_d[v] = avail_d[v] - 1'b1;
      if (in_valid_i && in_cred_vc_i == vc_t'(v)) avail_d[v] = avail_d[v] + in_cred_i;
      if (load && cred_any && cred_vc == vc_t'(v)) pend_d[v] = pend_d[v] - cred_amt;
      if (rx_valid_o[v] && rx_ready_i[v]) pend_d[v] = pend_d[v] + 1'b1;
      fifo_push[v] = in_valid_i && !in_cred_only_i && (in_vc_i == vc_t'(v));
      if (fifo_push[v] && !fifo_ready[v]) overflow_d = 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignments so all of them sample pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      avail_q     <= '{default: MaxCred};
      pend_q      <= '{default: '0};
      rr_tx_q     <= '0;
      rr_cred_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      hdr_q       <= '0;
      overflow_q  <= 1'b0;
    end else begin
      avail_q     <= avail_d;
      pend_q      <= pend_d;
      rr_tx_q     <= rr_tx_d;
      rr_cred_q   <= rr_cred_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      hdr_q       <= hdr_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid_o     = out_valid_q;
  assign out_data_o      = out_data_q;
  assign out_vc_o        = hdr_q.vc;
  assign out_cred_only_o = hdr_q.cred_only;
  assign out_cred_vc_o   = hdr_q.cred_vc;
  assign out_cred_o      = hdr_q.cred;
  assign in_ready_o      = 1'b1;
  assign overflow_o      = overflow_q;

  for (genvar v = 0; v < NumVc; v++) begin : g_vc
    stream_fifo #(
      .DATA_WIDTH (DataWidth),
      .DEPTH      (NumCredits)
    ) i_rx_fifo (
      .clk_i   (clk_i),
      .rst_ni  (1'b1),
      .flush_i (rst_i),
      .data_i  (in_data_i),
      .valid_i (fifo_push[v]),
      .ready_o (fifo_ready[v]),
      .data_o  (rx_data_o[v*DataWidth +: DataWidth]),
      .valid_o (rx_valid_o[v]),
      .ready_i (rx_ready_i[v])
    );

    a_avail_max: assert property (@(posedge clk_i) disable iff (rst_i) avail_q[v] <= MaxCred);
    a_pend_max:  assert property (@(posedge clk_i) disable iff (rst_i) pend_q[v] <= MaxCred);
  end

  a_out_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (out_valid_q && !out_ready_i) |=> (out_valid_q && $stable(out_data_q) && $stable(hdr_q)));
  a_thresh_pos: assert property (@(posedge clk_i) ForceSendThresh > 0);

endmodule
